// File: rtl/riscv_tohost_monitor_if.sv
// Data-memory write port as seen by the tohost monitor.
// The core side drives it; the monitor only listens.
interface riscv_tohost_monitor_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              dmem_wr_en;
    logic [ADDR_W-1:0] dmem_wr_addr;
    logic [31:0]       dmem_wr_data;
    logic [3:0]        dmem_wr_be;

    modport master (
        output dmem_wr_en,
        output dmem_wr_addr,
        output dmem_wr_data,
        output dmem_wr_be
    );

    modport slave (
        input dmem_wr_en,
        input dmem_wr_addr,
        input dmem_wr_data,
        input dmem_wr_be
    );
endinterface

// File: rtl/riscv_tohost_monitor.sv
// Decodes the riscv-tests tohost completion protocol from dmem stores: pass, fail(test_num) or timeout.
// Optional TOHOST_BE_CHECK_EN: a partial-width tohost store is reported as FAIL with test_num all-ones.
module riscv_tohost_monitor #(
    parameter int unsigned       ADDR_W         = 32,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR    = 32'h0000_1000,
    parameter int unsigned       TIMEOUT_CYCLES = 100000,
    parameter int unsigned       CNT_W          = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    riscv_tohost_monitor_if.slave   dmem,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic                    fail,
    output logic                    timeout,
    output logic [30:0]             test_num,
    output logic [CNT_W-1:0]        cycle_count
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_PASS,
        ST_FAIL,
        ST_TIMEOUT
    } state_t;

    state_t      state;
    logic        hit;
    logic        be_err;
    logic        dec_pass;
    logic        dec_fail;
    logic [30:0] fail_num;
    logic        tmo_hit;
    logic        unused_bits;

    always_comb begin
        hit = dmem.dmem_wr_en &&
              (dmem.dmem_wr_addr[ADDR_W-1:2] == TOHOST_ADDR[ADDR_W-1:2]);
`ifdef TOHOST_BE_CHECK_EN
        be_err = hit && (dmem.dmem_wr_be != 4'hF);
`else
        be_err = 1'b0;
`endif
        dec_pass = hit && !be_err && (dmem.dmem_wr_data == 32'd1);
        // A protocol error outranks whatever the data says.
        dec_fail = be_err ||
                   (hit && dmem.dmem_wr_data[0] && (dmem.dmem_wr_data[31:1] != '0));
        fail_num = be_err ? 31'h7FFF_FFFF : dmem.dmem_wr_data[31:1];
        tmo_hit  = (TIMEOUT_CYCLES != 0) &&
                   (cycle_count == CNT_W'(TIMEOUT_CYCLES - 1));
        unused_bits = &{1'b0, dmem.dmem_wr_be, dmem.dmem_wr_addr[1:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            timeout     <= 1'b0;
            test_num    <= '0;
            cycle_count <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    // The exit cycle is still a RUN cycle, so it is counted too.
                    if (cycle_count != '1)
                        cycle_count <= cycle_count + 1'b1;
                    if (dec_pass) begin
                        state <= ST_PASS;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= 1'b1;
                    end else if (dec_fail) begin
                        state    <= ST_FAIL;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        fail     <= 1'b1;
                        test_num <= fail_num;
                    end else if (tmo_hit) begin
                        state   <= ST_TIMEOUT;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end
                end
                default: begin
                    if (start) begin
                        state       <= ST_RUN;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        fail        <= 1'b0;
                        timeout     <= 1'b0;
                        test_num    <= '0;
                        cycle_count <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_tohost_monitor.sv
// Self-checking bench: three monitors (default, 20-cycle timeout, 4-bit counter with timeout off)
// share one stimulus stream and are checked every cycle against a per-test outcome model.
module tb_riscv_tohost_monitor;

    localparam int N = 3;

    logic clk = 1'b0;
    logic rst;
    logic start;
    always #5 clk = ~clk;

    riscv_tohost_monitor_if #(.ADDR_W(32)) bus ();

    logic        busy_o [N];
    logic        done_o [N];
    logic        pass_o [N];
    logic        fail_o [N];
    logic        tmo_o  [N];
    logic [30:0] num_o  [N];
    logic [31:0] cnt_a;
    logic [31:0] cnt_b;
    logic [3:0]  cnt_c;

    riscv_tohost_monitor dut_a (
        .clk(clk), .rst(rst), .start(start), .dmem(bus),
        .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]), .fail(fail_o[0]),
        .timeout(tmo_o[0]), .test_num(num_o[0]), .cycle_count(cnt_a)
    );

    riscv_tohost_monitor #(.TIMEOUT_CYCLES(20)) dut_b (
        .clk(clk), .rst(rst), .start(start), .dmem(bus),
        .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]), .fail(fail_o[1]),
        .timeout(tmo_o[1]), .test_num(num_o[1]), .cycle_count(cnt_b)
    );

    riscv_tohost_monitor #(.TIMEOUT_CYCLES(0), .CNT_W(4)) dut_c (
        .clk(clk), .rst(rst), .start(start), .dmem(bus),
        .busy(busy_o[2]), .done(done_o[2]), .pass(pass_o[2]), .fail(fail_o[2]),
        .timeout(tmo_o[2]), .test_num(num_o[2]), .cycle_count(cnt_c)
    );

    // Reference model: one record per monitor describing the current test.
    longint unsigned limit [N] = '{100000, 20, 0};
    longint unsigned cmax  [N] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hF};
    bit              m_run  [N];
    bit              m_pass [N];
    bit              m_fail [N];
    bit              m_tmo  [N];
    longint unsigned m_num  [N];
    longint unsigned m_cnt  [N];

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit          hit;
        logic [31:0] d;
        longint unsigned old;
        hit = bus.dmem_wr_en && (bus.dmem_wr_addr[31:2] == 30'h400);
        d   = bus.dmem_wr_data;
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                m_run[i] = 0; m_pass[i] = 0; m_fail[i] = 0; m_tmo[i] = 0;
                m_num[i] = 0; m_cnt[i] = 0;
            end else if (m_run[i]) begin
                old = m_cnt[i];
                if (m_cnt[i] < cmax[i]) m_cnt[i]++;
                if (hit) begin
`ifdef TOHOST_BE_CHECK_EN
                    if (bus.dmem_wr_be != 4'hF) begin
                        m_fail[i] = 1; m_num[i] = 64'h7FFF_FFFF;
                    end else
`endif
                    if (d == 32'd1) m_pass[i] = 1;
                    else if (d[0]) begin
                        m_fail[i] = 1; m_num[i] = longint'(d >> 1);
                    end
                end
                if (!m_pass[i] && !m_fail[i] && limit[i] != 0 && old == limit[i] - 1)
                    m_tmo[i] = 1;
                if (m_pass[i] || m_fail[i] || m_tmo[i]) m_run[i] = 0;
            end else if (start) begin
                m_run[i] = 1; m_pass[i] = 0; m_fail[i] = 0; m_tmo[i] = 0;
                m_num[i] = 0; m_cnt[i] = 0;
            end
        end
    endtask

    task automatic check_all();
        logic [63:0] cnt;
        for (int i = 0; i < N; i++) begin
            cnt = (i == 0) ? 64'(cnt_a) : (i == 1) ? 64'(cnt_b) : 64'(cnt_c);
            chk($sformatf("busy[%0d]", i), 64'(busy_o[i]), 64'(m_run[i]));
            chk($sformatf("done[%0d]", i), 64'(done_o[i]), 64'(m_pass[i] | m_fail[i] | m_tmo[i]));
            chk($sformatf("pass[%0d]", i), 64'(pass_o[i]), 64'(m_pass[i]));
            chk($sformatf("fail[%0d]", i), 64'(fail_o[i]), 64'(m_fail[i]));
            chk($sformatf("timeout[%0d]", i), 64'(tmo_o[i]), 64'(m_tmo[i]));
            chk($sformatf("test_num[%0d]", i), 64'(num_o[i]), m_num[i]);
            chk($sformatf("cycle_count[%0d]", i), cnt, m_cnt[i]);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        start           = 1'b0;
        bus.dmem_wr_en  = 1'b0;
        bus.dmem_wr_addr = '0;
        bus.dmem_wr_data = '0;
        bus.dmem_wr_be  = 4'h0;
        check_all();
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        bus.dmem_wr_en   = 1'b1;
        bus.dmem_wr_addr = addr;
        bus.dmem_wr_data = data;
        bus.dmem_wr_be   = be;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        int unsigned r;
        rst = 1'b1; start = 1'b0;
        bus.dmem_wr_en = 1'b0; bus.dmem_wr_addr = '0; bus.dmem_wr_data = '0; bus.dmem_wr_be = '0;
        for (int i = 0; i < N; i++) begin
            m_run[i] = 0; m_pass[i] = 0; m_fail[i] = 0; m_tmo[i] = 0; m_num[i] = 0; m_cnt[i] = 0;
        end
        tick();
        tick();
        chk("reset_busy", 64'(busy_o[0]), 64'd0);
        chk("reset_done", 64'(done_o[0]), 64'd0);
        rst = 1'b0;

        // Pass after 50 idle cycles.
        start = 1'b1; tick();
        repeat (50) tick();
        store(32'h1000, 32'h1, 4'hF); tick();
        chk("t1_pass", 64'(pass_o[0]), 64'd1);
        chk("t1_done", 64'(done_o[0]), 64'd1);
        chk("t1_busy", 64'(busy_o[0]), 64'd0);
        chk("t1_count", 64'(cnt_a), 64'd51);
        chk("t1_num", 64'(num_o[0]), 64'd0);
        chk("t1_sat", 64'(cnt_c), 64'd15);

        // Fail with test 3, then a fresh pass.
        start = 1'b1; tick();
        store(32'h1000, 32'h7, 4'hF); tick();
        chk("t2_fail", 64'(fail_o[0]), 64'd1);
        chk("t2_num", 64'(num_o[0]), 64'd3);
        start = 1'b1; tick();
        store(32'h1000, 32'h1, 4'hF); tick();
        chk("t2_pass", 64'(pass_o[0]), 64'd1);
        chk("t2_fail_clr", 64'(fail_o[0]), 64'd0);
        chk("t2_num_clr", 64'(num_o[0]), 64'd0);

        // Timeout exactly 20 cycles after start; later hits ignored.
        start = 1'b1; tick();
        repeat (19) tick();
        chk("t3_no_tmo_yet", 64'(tmo_o[1]), 64'd0);
        tick();
        chk("t3_tmo", 64'(tmo_o[1]), 64'd1);
        chk("t3_tmo_off", 64'(tmo_o[2]), 64'd0);
        store(32'h1000, 32'h1, 4'hF); tick();
        chk("t3_hold_tmo", 64'(tmo_o[1]), 64'd1);
        chk("t3_hold_pass", 64'(pass_o[1]), 64'd0);

        // Non-decisive stores keep RUN.
        start = 1'b1; tick();
        store(32'h1004, 32'h1, 4'hF); tick();
        store(32'h1000, 32'h2, 4'hF); tick();
        store(32'h1000, 32'h0, 4'hF); tick();
        chk("t4_busy", 64'(busy_o[0]), 64'd1);
        store(32'h1000, 32'h1, 4'hF); tick();
        chk("t4_pass", 64'(pass_o[0]), 64'd1);

        // Decisive hit wins over the timeout in the same cycle.
        start = 1'b1; tick();
        repeat (19) tick();
        store(32'h1000, 32'hB, 4'hF); tick();
        chk("t5_fail", 64'(fail_o[1]), 64'd1);
        chk("t5_num", 64'(num_o[1]), 64'd5);
        chk("t5_tmo", 64'(tmo_o[1]), 64'd0);

        // Reset mid-run.
        start = 1'b1; tick();
        repeat (5) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t6_busy", 64'(busy_o[0]), 64'd0);
        chk("t6_count", 64'(cnt_a), 64'd0);

        // Byte-enable handling on a partial tohost store.
        start = 1'b1; tick();
        store(32'h1000, 32'h1, 4'h1); tick();
`ifdef TOHOST_BE_CHECK_EN
        chk("t7_fail", 64'(fail_o[0]), 64'd1);
        chk("t7_num", 64'(num_o[0]), 64'h7FFF_FFFF);
`else
        chk("t7_pass", 64'(pass_o[0]), 64'd1);
`endif

        // Randomized tests.
        for (int t = 0; t < 30; t++) begin
            start = 1'b1; tick();
            for (int c = 0; c < 40; c++) begin
                r = $urandom_range(99);
                if (r < 8) begin
                    a = 32'h1000 | 32'($urandom_range(3));
                    case ($urandom_range(3))
                        0: d = 32'h1;
                        1: d = $urandom | 32'h3;
                        2: d = $urandom & ~32'h1;
                        default: d = 32'h0;
                    endcase
                    store(a, d, ($urandom_range(3) == 0) ? 4'($urandom) : 4'hF);
                end else if (r < 30) begin
                    a = $urandom;
                    if (a[31:2] == 30'h400) a[5] = 1'b1;
                    store(a, (r < 20) ? 32'h1 : $urandom, 4'hF);
                end
                if ($urandom_range(19) == 0) start = 1'b1;
                if ($urandom_range(199) == 0) rst = 1'b1;
                tick();
                rst = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
